// File: rtl/soc_rr_arbiter.sv
// Latching request arbiter: fixed-priority high masters, round-robin low masters,
// zero-cycle grant latency, grants held while the owner keeps requesting.
module soc_rr_arbiter #(
  parameter  int NUM_REQ      = 3,
  parameter  int NUM_HIGH     = 1,
  parameter  int STARVE_LIMIT = 4,
  localparam int IDX_W        = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               res_n,
  input  logic [NUM_REQ-1:0] requests,
  output logic [NUM_REQ-1:0] grant,
  output logic               grant_valid,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               new_grant
);

  localparam int NUM_LOW   = NUM_REQ - NUM_HIGH;
  localparam bit STARVE_EN = (STARVE_LIMIT > 0) && (NUM_HIGH > 0) && (NUM_LOW > 0);
  localparam int SC_W      = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

  localparam logic [NUM_REQ-1:0] HIGH_MASK = NUM_REQ'((1 << NUM_HIGH) - 1);
  localparam logic [NUM_REQ-1:0] LOW_MASK  = ~HIGH_MASK;
  localparam logic [IDX_W-1:0]   RR_FIRST  = (NUM_LOW > 0) ? IDX_W'(NUM_HIGH) : '0;
  localparam logic [IDX_W-1:0]   RR_LAST   = IDX_W'(NUM_REQ - 1);
  localparam logic [SC_W-1:0]    SC_MAX    = SC_W'(STARVE_LIMIT);

  logic [NUM_REQ-1:0] owner_q, owner_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [SC_W-1:0]    starve_cnt_q, starve_cnt_d;
  logic               starve_flag_q, starve_flag_d;

  logic [NUM_REQ-1:0] high_req, low_req, rr_oh, hi_oh, pick;
  logic [IDX_W-1:0]   rr_idx;
  logic               hold, rr_hit, hi_hit;

  // NOTE: every signal driven here gets a default first, so no path can leave
  // a value unassigned and infer a latch.
  always_comb begin
    high_req = requests & HIGH_MASK;
    low_req  = requests & LOW_MASK;
    hold     = |(owner_q & requests);

    // Descending scans so the lowest qualifying index is the last one written.
    rr_hit = 1'b0;
    rr_idx = '0;
    rr_oh  = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (low_req[k] && (IDX_W'(k) >= rr_ptr_q)) begin
        rr_hit = 1'b1;
        rr_idx = IDX_W'(k);
        rr_oh  = '0;
        rr_oh[k] = 1'b1;
      end
    end
    if (!rr_hit) begin
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
        if (low_req[k]) begin
          rr_hit = 1'b1;
          rr_idx = IDX_W'(k);
          rr_oh  = '0;
          rr_oh[k] = 1'b1;
        end
      end
    end

    hi_hit = 1'b0;
    hi_oh  = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (high_req[k]) begin
        hi_hit = 1'b1;
        hi_oh  = '0;
        hi_oh[k] = 1'b1;
      end
    end

    if (hold)                         pick = owner_q;
    else if (starve_flag_q && rr_hit) pick = rr_oh;
    else if (hi_hit)                  pick = hi_oh;
    else if (rr_hit)                  pick = rr_oh;
    else                              pick = '0;

    // Outputs are forced low for the whole reset, not just from the next edge.
    grant       = res_n ? pick : '0;
    new_grant   = res_n && !hold && (|requests);
    grant_valid = |grant;
    grant_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant[k]) grant_idx = IDX_W'(k);
    end

    owner_d       = grant;
    rr_ptr_d      = rr_ptr_q;
    starve_cnt_d  = starve_cnt_q;
    starve_flag_d = starve_flag_q;
    if (new_grant) begin
      if (|(grant & LOW_MASK)) begin
        rr_ptr_d      = (rr_idx == RR_LAST) ? RR_FIRST : rr_idx + 1'b1;
        starve_cnt_d  = '0;
        starve_flag_d = 1'b0;
      end else if (STARVE_EN && (|low_req) && (starve_cnt_q != SC_MAX)) begin
        starve_cnt_d  = starve_cnt_q + 1'b1;
        starve_flag_d = ((starve_cnt_q + 1'b1) == SC_MAX);
      end
    end
  end

  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      owner_q       <= '0;
      rr_ptr_q      <= RR_FIRST;
      starve_cnt_q  <= '0;
      starve_flag_q <= 1'b0;
    end else begin
      owner_q       <= owner_d;
      rr_ptr_q      <= rr_ptr_d;
      starve_cnt_q  <= starve_cnt_d;
      starve_flag_q <= starve_flag_d;
    end
  end

  a_onehot: assert property (@(posedge clk) disable iff (!res_n) $onehot0(grant));
  a_subset: assert property (@(posedge clk) disable iff (!res_n) (grant & ~requests) == '0);
  a_valid:  assert property (@(posedge clk) disable iff (!res_n) grant_valid == (grant != '0));
  a_index:  assert property (@(posedge clk) disable iff (!res_n)
                             grant_valid ? grant[grant_idx] : (grant_idx == '0));

endmodule

// File: tb/tb_soc_rr_arbiter.sv
// Directed-vector bench for soc_rr_arbiter: default, 5-master and short
// starvation-limit instances, followed by a random invariant sweep.
module tb_soc_rr_arbiter;

  typedef struct {
    logic [4:0] req;
    logic [4:0] gnt;
    logic       ng;
    logic [2:0] idx;
  } vec_t;

  logic clk = 1'b0;
  logic res_n;

  logic [2:0] req_a, gnt_a;
  logic       val_a, ng_a;
  logic [1:0] idx_a;
  logic [4:0] req_b, gnt_b;
  logic       val_b, ng_b;
  logic [2:0] idx_b;
  logic [2:0] req_c, gnt_c;
  logic       val_c, ng_c;
  logic [1:0] idx_c;

  int n_pass  = 0;
  int n_total = 0;

  vec_t tab_a[$];
  vec_t tab_b[$];
  vec_t tab_c[$];

  always #5 clk = ~clk;

  soc_rr_arbiter #(.NUM_REQ(3), .NUM_HIGH(1), .STARVE_LIMIT(4)) dut_a (
    .clk(clk), .res_n(res_n), .requests(req_a), .grant(gnt_a),
    .grant_valid(val_a), .grant_idx(idx_a), .new_grant(ng_a));

  soc_rr_arbiter #(.NUM_REQ(5), .NUM_HIGH(2), .STARVE_LIMIT(4)) dut_b (
    .clk(clk), .res_n(res_n), .requests(req_b), .grant(gnt_b),
    .grant_valid(val_b), .grant_idx(idx_b), .new_grant(ng_b));

  soc_rr_arbiter #(.NUM_REQ(3), .NUM_HIGH(2), .STARVE_LIMIT(2)) dut_c (
    .clk(clk), .res_n(res_n), .requests(req_c), .grant(gnt_c),
    .grant_valid(val_c), .grant_idx(idx_c), .new_grant(ng_c));

  function automatic vec_t mk(logic [4:0] r, logic [4:0] g, logic n, logic [2:0] i);
    vec_t v;
    v.req = r;
    v.gnt = g;
    v.ng  = n;
    v.idx = i;
    return v;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic drive(int sel, logic [4:0] r);
    case (sel)
      0:       req_a = r[2:0];
      1:       req_b = r;
      default: req_c = r[2:0];
    endcase
  endtask

  task automatic sample(int sel, output logic [4:0] g, output logic v,
                        output logic n, output logic [2:0] i);
    case (sel)
      0:       begin g = {2'b00, gnt_a}; v = val_a; n = ng_a; i = {1'b0, idx_a}; end
      1:       begin g = gnt_b;          v = val_b; n = ng_b; i = idx_b;         end
      default: begin g = {2'b00, gnt_c}; v = val_c; n = ng_c; i = {1'b0, idx_c}; end
    endcase
  endtask

  task automatic run_vec(int sel, vec_t v, string tag);
    logic [4:0] g;
    logic       val, n;
    logic [2:0] i;
    @(negedge clk);
    drive(sel, v.req);
    #1;
    sample(sel, g, val, n, i);
    check({tag, ".grant"},     32'(g),   32'(v.gnt));
    check({tag, ".new_grant"}, 32'(n),   32'(v.ng));
    check({tag, ".grant_idx"}, 32'(i),   32'(v.idx));
    check({tag, ".valid"},     32'(val), 32'(v.gnt != 5'd0));
  endtask

  function automatic logic inv_ok(logic [4:0] r, logic [4:0] g, logic [4:0] pg,
                                  logic v, logic n, logic [2:0] i);
    logic ok;
    ok = $onehot0(g) && ((g & ~r) == 5'd0) && (v == (g != 5'd0))
         && ((g == 5'd0) ? (i == 3'd0) : g[i]);
    if ((pg & r) != 5'd0) ok = ok && (g == pg) && !n;
    else                  ok = ok && (n == (r != 5'd0));
    return ok;
  endfunction

  initial begin
    // Default instance: RR alternation, hold, same-cycle handover, re-arbitration.
    tab_a.push_back(mk(5'b000, 5'b000, 0, 0));
    tab_a.push_back(mk(5'b110, 5'b010, 1, 1));
    tab_a.push_back(mk(5'b110, 5'b010, 0, 1));
    tab_a.push_back(mk(5'b110, 5'b010, 0, 1));
    tab_a.push_back(mk(5'b110, 5'b010, 0, 1));
    tab_a.push_back(mk(5'b100, 5'b100, 1, 2));
    tab_a.push_back(mk(5'b000, 5'b000, 0, 0));
    tab_a.push_back(mk(5'b110, 5'b010, 1, 1));
    tab_a.push_back(mk(5'b011, 5'b010, 0, 1));
    tab_a.push_back(mk(5'b001, 5'b001, 1, 0));
    tab_a.push_back(mk(5'b001, 5'b001, 0, 0));
    tab_a.push_back(mk(5'b101, 5'b001, 0, 0));
    tab_a.push_back(mk(5'b100, 5'b100, 1, 2));
    tab_a.push_back(mk(5'b001, 5'b001, 1, 0));
    tab_a.push_back(mk(5'b000, 5'b000, 0, 0));
    tab_a.push_back(mk(5'b010, 5'b010, 1, 1));
    tab_a.push_back(mk(5'b000, 5'b000, 0, 0));
    tab_a.push_back(mk(5'b110, 5'b100, 1, 2));
    tab_a.push_back(mk(5'b000, 5'b000, 0, 0));
    tab_a.push_back(mk(5'b010, 5'b010, 1, 1));
    tab_a.push_back(mk(5'b100, 5'b100, 1, 2));
    tab_a.push_back(mk(5'b110, 5'b100, 0, 2));

    // Five masters, two high: low owners rotate 3,4,3,4; high 1 beats low.
    tab_b.push_back(mk(5'b11000, 5'b01000, 1, 3));
    tab_b.push_back(mk(5'b11000, 5'b01000, 0, 3));
    tab_b.push_back(mk(5'b10000, 5'b10000, 1, 4));
    tab_b.push_back(mk(5'b11000, 5'b10000, 0, 4));
    tab_b.push_back(mk(5'b01000, 5'b01000, 1, 3));
    tab_b.push_back(mk(5'b11000, 5'b01000, 0, 3));
    tab_b.push_back(mk(5'b10000, 5'b10000, 1, 4));
    tab_b.push_back(mk(5'b11010, 5'b10000, 0, 4));
    tab_b.push_back(mk(5'b01010, 5'b00010, 1, 1));
    tab_b.push_back(mk(5'b00000, 5'b00000, 0, 0));

    // Starvation limit 2: two high wins, then low 2 jumps the queue; count restarts.
    tab_c.push_back(mk(5'b101, 5'b001, 1, 0));
    tab_c.push_back(mk(5'b110, 5'b010, 1, 1));
    tab_c.push_back(mk(5'b101, 5'b100, 1, 2));
    tab_c.push_back(mk(5'b011, 5'b001, 1, 0));
    tab_c.push_back(mk(5'b110, 5'b010, 1, 1));
    tab_c.push_back(mk(5'b101, 5'b001, 1, 0));
    tab_c.push_back(mk(5'b111, 5'b001, 0, 0));
    tab_c.push_back(mk(5'b110, 5'b100, 1, 2));
    tab_c.push_back(mk(5'b000, 5'b000, 0, 0));

    res_n = 1'b0;
    req_a = 3'b111;
    req_b = 5'b11111;
    req_c = 3'b111;
    #1;
    check("reset.grant_a", 32'(gnt_a), 32'd0);
    check("reset.grant_b", 32'(gnt_b), 32'd0);
    check("reset.grant_c", 32'(gnt_c), 32'd0);
    check("reset.ng_a",    32'(ng_a),  32'd0);
    check("reset.valid_a", 32'(val_a), 32'd0);
    check("reset.idx_b",   32'(idx_b), 32'd0);

    @(negedge clk);
    req_a = '0;
    req_b = '0;
    req_c = '0;
    res_n = 1'b1;

    foreach (tab_a[i]) run_vec(0, tab_a[i], $sformatf("a%0d", i));

    // Mid-transaction reset: owner 2 held with 3'b110, grant must drop at once.
    @(negedge clk);
    res_n = 1'b0;
    #1;
    check("midrst.grant", 32'(gnt_a), 32'd0);
    check("midrst.valid", 32'(val_a), 32'd0);
    check("midrst.idx",   32'(idx_a), 32'd0);
    check("midrst.ng",    32'(ng_a),  32'd0);
    @(negedge clk);
    res_n = 1'b1;
    #1;
    check("postrst.grant", 32'(gnt_a), 32'b010);
    check("postrst.ng",    32'(ng_a),  32'd1);
    check("postrst.idx",   32'(idx_a), 32'd1);
    @(negedge clk);
    req_a = '0;

    foreach (tab_b[i]) run_vec(1, tab_b[i], $sformatf("b%0d", i));
    foreach (tab_c[i]) run_vec(2, tab_c[i], $sformatf("c%0d", i));

    begin
      logic [4:0] ra, rb, rc, pa, pb, pc, g, m;
      logic       v, n;
      logic [2:0] i;
      ra = '0; rb = '0; rc = '0;
      pa = '0; pb = '0; pc = '0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
        @(negedge clk);
        for (int b = 0; b < 5; b++) m[b] = ($urandom_range(3) == 0);
        ra = (ra ^ m) & 5'b00111;
        for (int b = 0; b < 5; b++) m[b] = ($urandom_range(3) == 0);
        rb = rb ^ m;
        for (int b = 0; b < 5; b++) m[b] = ($urandom_range(3) == 0);
        rc = (rc ^ m) & 5'b00111;
        drive(0, ra);
        drive(1, rb);
        drive(2, rc);
        #1;
        sample(0, g, v, n, i);
        check($sformatf("rand_a%0d", cyc), 32'(inv_ok(ra, g, pa, v, n, i)), 32'd1);
        pa = g;
        sample(1, g, v, n, i);
        check($sformatf("rand_b%0d", cyc), 32'(inv_ok(rb, g, pb, v, n, i)), 32'd1);
        pb = g;
        sample(2, g, v, n, i);
        check($sformatf("rand_c%0d", cyc), 32'(inv_ok(rc, g, pc, v, n, i)), 32'd1);
        pc = g;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
